// File: rtl/usbfs_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usbfs_tx_sched: shares the FS packet sender between handshakes and N_EP  |
// | IN-endpoint data sources. Build macro: USBFS_TX_SCHED_RR_EN (RR arb).    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module usbfs_tx_sched #(
    parameter int N_EP   = 4,
    parameter int MAXPKT = 64,
    localparam int L = (MAXPKT > 0) ? $clog2(MAXPKT + 1) : 1,
    localparam int G = (N_EP > 1) ? $clog2(N_EP) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hs_req,
    input  logic [3:0]        hs_pid,
    output logic              hs_done,
    input  logic [N_EP-1:0]   ep_req,
    input  logic [N_EP*L-1:0] ep_len,
    output logic [N_EP-1:0]   ep_byte_req,
    input  logic [N_EP*8-1:0] ep_byte,
    output logic [N_EP-1:0]   ep_sent,
    input  logic [N_EP-1:0]   ep_ack,
    input  logic [N_EP-1:0]   ep_tgl_clr,
    output logic [N_EP-1:0]   ep_tgl,
    output logic              busy,
    output logic              tp_sta,
    output logic [3:0]        tp_pid,
    input  logic              tp_byte_req,
    output logic [7:0]        tp_byte,
    output logic              tp_fin_n,
    input  logic              tx_fin
);

    // SEND also covers the wait for tx_fin; there is no separate WAIT encoding.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            is_hs_q, is_hs_d;
    logic [G-1:0]    grant_q, grant_d;
    logic [L-1:0]    len_q, len_d;
    logic [L-1:0]    cnt_q, cnt_d;
    logic [3:0]      pid_q, pid_d;
    logic            fetch_q, fetch_d;
    logic [7:0]      byte_q, byte_d;
    logic            fin_q, fin_d;
    logic [N_EP-1:0] tgl_q;

    logic            w_any;
    logic [G-1:0]    w_sel;
    logic [L-1:0]    w_len_raw;
    logic [L-1:0]    w_len;
    logic [7:0]      w_ep_byte;
    logic [3:0]      w_data_pid;

`ifdef USBFS_TX_SCHED_RR_EN
    logic [G-1:0]    ptr_q, ptr_d;

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 0; k < N_EP; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_EP;
            if (!w_any && ep_req[idx]) begin
                w_any = 1'b1;
                w_sel = G'(idx);
            end
        end
    end
`else
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = N_EP - 1; k >= 0; k--) begin
            if (ep_req[k]) begin
                w_any = 1'b1;
                w_sel = G'(k);
            end
        end
    end
`endif

    assign w_len_raw  = ep_len[w_sel*L +: L];
    assign w_len      = (w_len_raw > L'(MAXPKT)) ? L'(MAXPKT) : w_len_raw;
    assign w_ep_byte  = ep_byte[grant_q*8 +: 8];
    assign w_data_pid = tgl_q[grant_q] ? 4'b1011 : 4'b0011;

    always_comb begin
        state_d = state_q;
        is_hs_d = is_hs_q;
        grant_d = grant_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        pid_d   = pid_q;
        fetch_d = 1'b0;
        fin_d   = fin_q;
        byte_d  = fetch_q ? w_ep_byte : byte_q;
`ifdef USBFS_TX_SCHED_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (hs_req) begin
                    is_hs_d = 1'b1;
                    pid_d   = hs_pid;
                    len_d   = '0;
                    cnt_d   = '0;
                    state_d = START;
                end else if (w_any) begin
                    is_hs_d = 1'b0;
                    grant_d = w_sel;
                    len_d   = w_len;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (!is_hs_q) pid_d = w_data_pid;
                state_d = SEND;
            end
            SEND: begin
                if (tx_fin) begin
                    state_d = DONE;
                end else if (tp_byte_req) begin
                    if (cnt_q < len_q) begin
                        fetch_d = 1'b1;
                        fin_d   = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        fin_d   = 1'b0;
                    end
                end
            end
            default: begin
                fin_d   = 1'b1;
                state_d = IDLE;
`ifdef USBFS_TX_SCHED_RR_EN
                if (!is_hs_q)
                    ptr_d = (grant_q == G'(N_EP - 1)) ? '0 : grant_q + 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            is_hs_q <= 1'b0;
            grant_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            pid_q   <= 4'b0000;
            fetch_q <= 1'b0;
            byte_q  <= 8'h00;
            fin_q   <= 1'b1;
            tgl_q   <= '0;
`ifdef USBFS_TX_SCHED_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            is_hs_q <= is_hs_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            pid_q   <= pid_d;
            fetch_q <= fetch_d;
            byte_q  <= byte_d;
            fin_q   <= fin_d;
            // Clear dominates a simultaneous ACK.
            tgl_q   <= (tgl_q ^ ep_ack) & ~ep_tgl_clr;
`ifdef USBFS_TX_SCHED_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign tp_sta      = (state_q == START);
    assign tp_pid      = (state_q == START && !is_hs_q) ? w_data_pid : pid_q;
    assign tp_byte     = fetch_q ? w_ep_byte : byte_q;
    assign tp_fin_n    = fin_q;
    assign ep_byte_req = fetch_d ? (N_EP'(1) << grant_q) : '0;
    assign ep_sent     = (state_q == DONE && !is_hs_q) ? (N_EP'(1) << grant_q) : '0;
    assign hs_done     = (state_q == DONE) && is_hs_q;
    assign ep_tgl      = tgl_q;

endmodule
`default_nettype wire

// File: tb/tb_usbfs_tx_sched.sv
`default_nettype none
// Bench for usbfs_tx_sched: a sender/endpoint model drives packets, a scoreboard
// holds the expected grant order, PIDs and byte stream.
module tb_usbfs_tx_sched;
    localparam int N_EP = 4;
    localparam int MAXPKT = 64;
    localparam int L = 7;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              hs_req = 1'b0;
    logic [3:0]        hs_pid = 4'b0000;
    logic              hs_done;
    logic [N_EP-1:0]   ep_req = '0;
    logic [N_EP*L-1:0] ep_len = '0;
    logic [N_EP-1:0]   ep_byte_req;
    logic [N_EP*8-1:0] ep_byte = '0;
    logic [N_EP-1:0]   ep_sent;
    logic [N_EP-1:0]   ep_ack = '0;
    logic [N_EP-1:0]   ep_tgl_clr = '0;
    logic [N_EP-1:0]   ep_tgl;
    logic              busy;
    logic              tp_sta;
    logic [3:0]        tp_pid;
    logic              tp_byte_req = 1'b0;
    logic [7:0]        tp_byte;
    logic              tp_fin_n;
    logic              tx_fin = 1'b0;

    int nvec = 0;
    int nerr = 0;

    int         exp_ep_q[$];
    logic [3:0] exp_pid_q[$];
    logic [8:0] sb_q[$];
    logic [7:0] data_q[$];

    usbfs_tx_sched #(.N_EP(N_EP), .MAXPKT(MAXPKT)) dut (
        .clk(clk), .rstn(rstn),
        .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
        .ep_req(ep_req), .ep_len(ep_len), .ep_byte_req(ep_byte_req),
        .ep_byte(ep_byte), .ep_sent(ep_sent), .ep_ack(ep_ack),
        .ep_tgl_clr(ep_tgl_clr), .ep_tgl(ep_tgl), .busy(busy),
        .tp_sta(tp_sta), .tp_pid(tp_pid), .tp_byte_req(tp_byte_req),
        .tp_byte(tp_byte), .tp_fin_n(tp_fin_n), .tx_fin(tx_fin)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Queue one data packet: n payload bytes base, base+step, ... then the end marker.
    task automatic push_pkt(input int ep, input logic [3:0] pid, input int n,
                            input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b;
        exp_ep_q.push_back(ep);
        exp_pid_q.push_back(pid);
        b = base;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({1'b1, b});
            data_q.push_back(b);
            b = b + step;
        end
        sb_q.push_back(9'h000);
    endtask

    task automatic push_hs(input logic [3:0] pid);
        exp_ep_q.push_back(-1);
        exp_pid_q.push_back(pid);
    endtask

    task automatic set_len(input int ep, input int len);
        ep_len[ep*L +: L] = L'(len);
    endtask

    // Sender model: waits for tp_sta, pulls bytes, ends with tx_fin, checks completion.
    task automatic do_packet(input bit clr);
        int ep;
        logic [3:0] epid;
        logic [8:0] e;
        logic [N_EP-1:0] br;
        logic [N_EP-1:0] oh;
        int k;
        bit done;
        ep   = exp_ep_q.pop_front();
        epid = exp_pid_q.pop_front();
        oh   = (ep >= 0) ? (N_EP'(1) << ep) : '0;
        #1;
        k = 0;
        while (!tp_sta && k < 30) begin
            @(negedge clk); #1; k++;
        end
        nvec++;
        if (tp_sta !== 1'b1) begin
            nerr++;
            $display("FAIL tp_sta_wait: got %b want 1 (ep %0d)", tp_sta, ep);
            return;
        end
        nvec++;
        if (tp_pid !== epid) begin
            nerr++;
            $display("FAIL tp_pid: got %b want %b (ep %0d)", tp_pid, epid, ep);
        end
        @(negedge clk); #1;
        nvec++;
        if (tp_sta !== 1'b0 || tp_pid !== epid) begin
            nerr++;
            $display("FAIL sta_pulse_pid_hold: sta %b pid %b want 0 %b", tp_sta, tp_pid, epid);
        end
        if (ep >= 0) begin
            done = 1'b0;
            for (int n = 0; n < 80 && !done; n++) begin
                tp_byte_req = 1'b1; #1;
                br = ep_byte_req;
                @(negedge clk);
                tp_byte_req = 1'b0;
                if (sb_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL scoreboard_empty: got req with no expected entry want none");
                    done = 1'b1;
                end else begin
                    e = sb_q.pop_front();
                    if (br[ep] && data_q.size() > 0) ep_byte[ep*8 +: 8] = data_q.pop_front();
                    #1;
                    nvec++;
                    if (br !== (e[8] ? oh : '0)) begin
                        nerr++;
                        $display("FAIL ep_byte_req: got %b want %b", br, e[8] ? oh : '0);
                    end
                    nvec++;
                    if (tp_fin_n !== e[8] || (e[8] && tp_byte !== e[7:0])) begin
                        nerr++;
                        $display("FAIL tp_byte: got fin_n %b byte %h want fin_n %b byte %h",
                                 tp_fin_n, tp_byte, e[8], e[7:0]);
                    end
                    if (!e[8]) done = 1'b1;
                    @(negedge clk);
                end
            end
            if (!done) begin
                nvec++; nerr++;
                $display("FAIL byte_loop: got no end marker want tp_fin_n=0");
            end
        end else begin
            @(negedge clk); #1;
            nvec++;
            if (ep_byte_req !== '0) begin
                nerr++;
                $display("FAIL hs_no_byte_req: got %b want 0", ep_byte_req);
            end
            @(negedge clk);
        end
        tx_fin = 1'b1;
        @(negedge clk);
        tx_fin = 1'b0;
        #1;
        nvec++;
        if (hs_done !== (ep < 0) || ep_sent !== oh) begin
            nerr++;
            $display("FAIL completion: got hs_done %b ep_sent %b want %b %b",
                     hs_done, ep_sent, (ep < 0), oh);
        end
        if (clr) begin
            if (ep < 0) hs_req = 1'b0;
            else ep_req[ep] = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        #1;
        nvec++;
        if ({busy, tp_sta, tp_pid, tp_fin_n, ep_tgl, hs_done, ep_sent, ep_byte_req, tp_byte}
            !== {1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00}) begin
            nerr++;
            $display("FAIL reset_state: busy %b sta %b pid %h fin_n %b tgl %b byte %h want 0 0 0 1 0 00",
                     busy, tp_sta, tp_pid, tp_fin_n, ep_tgl, tp_byte);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_handshake;
        push_hs(4'b1010);
        hs_pid = 4'b1010;
        hs_req = 1'b1;
        do_packet(1'b1);
        @(negedge clk);
    endtask

    task automatic test_data_toggle;
        set_len(1, 3);
        push_pkt(1, 4'b0011, 3, 8'hA1, 8'h11);
        ep_req[1] = 1'b1;
        do_packet(1'b1);
        @(negedge clk);
        ep_ack[1] = 1'b1;
        @(negedge clk);
        ep_ack[1] = 1'b0;
        #1;
        nvec++;
        if (ep_tgl !== 4'b0010) begin
            nerr++;
            $display("FAIL ack_flip: got %b want 0010", ep_tgl);
        end
        set_len(1, 2);
        push_pkt(1, 4'b1011, 2, 8'h5A, 8'h01);
        ep_req[1] = 1'b1;
        do_packet(1'b1);
        @(negedge clk);
    endtask

    task automatic test_zero_len;
        set_len(0, 0);
        push_pkt(0, 4'b0011, 0, 8'h00, 8'h00);
        ep_req[0] = 1'b1;
        do_packet(1'b1);
        @(negedge clk);
    endtask

    task automatic test_clamp;
        set_len(3, 100);
        push_pkt(3, 4'b0011, MAXPKT, 8'h03, 8'h07);
        ep_req[3] = 1'b1;
        do_packet(1'b1);
        @(negedge clk);
    endtask

    task automatic test_arb;
        int order[3];
`ifdef USBFS_TX_SCHED_RR_EN
        order = '{0, 2, 0};
`else
        order = '{0, 0, 0};
`endif
        set_len(0, 1);
        set_len(2, 1);
        for (int i = 0; i < 3; i++)
            push_pkt(order[i], 4'b0011, 1, 8'(8'h30 + 8'(i) * 8'h11), 8'h00);
        ep_req = 4'b0101;
        for (int i = 0; i < 3; i++) do_packet(1'b0);
        ep_req = 4'b0000;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_hs_priority;
        set_len(2, 2);
        set_len(1, 1);
        push_pkt(2, 4'b0011, 2, 8'hC0, 8'h01);
        push_hs(4'b0010);
        push_pkt(1, 4'b1011, 1, 8'hE7, 8'h00);
        ep_req = 4'b0100;
        @(negedge clk);
        hs_pid = 4'b0010;
        hs_req = 1'b1;
        ep_req = 4'b0110;
        for (int i = 0; i < 3; i++) do_packet(1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int k;
        set_len(1, 3);
        ep_req = 4'b0010;
        k = 0;
        #1;
        while (!tp_sta && k < 30) begin
            @(negedge clk); #1; k++;
        end
        @(negedge clk);
        tp_byte_req = 1'b1;
        @(negedge clk);
        tp_byte_req = 1'b0;
        ep_byte[15:8] = 8'h77;
        rstn = 1'b0;
        #1;
        nvec++;
        if ({busy, tp_sta, tp_pid, tp_fin_n, ep_tgl, hs_done, ep_sent, ep_byte_req, tp_byte}
            !== {1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00}) begin
            nerr++;
            $display("FAIL abort_state: busy %b sta %b pid %h fin_n %b tgl %b byte %h want 0 0 0 1 0 00",
                     busy, tp_sta, tp_pid, tp_fin_n, ep_tgl, tp_byte);
        end
        ep_req = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            nvec++;
            if (ep_sent !== 4'b0000 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL abort_no_sent: got sent %b busy %b want 0000 0", ep_sent, busy);
            end
        end
        ep_ack = 4'b1000;
        @(negedge clk);
        ep_ack = 4'b0000;
        #1;
        nvec++;
        if (ep_tgl !== 4'b1000) begin
            nerr++;
            $display("FAIL ack_ep3: got %b want 1000", ep_tgl);
        end
        ep_ack = 4'b1000;
        ep_tgl_clr = 4'b1000;
        @(negedge clk);
        ep_ack = 4'b0000;
        ep_tgl_clr = 4'b0000;
        #1;
        nvec++;
        if (ep_tgl !== 4'b0000) begin
            nerr++;
            $display("FAIL clr_wins: got %b want 0000", ep_tgl);
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_data_toggle();
        test_zero_len();
        test_clamp();
        test_arb();
        test_hs_priority();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
